// File: rtl/tx_pkg.sv
// Shared types and default sizing for the tx scheduling slice.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } tx_sched_state_t;

  localparam int TX_WIDTH                = 16;
  localparam int TX_DEFAULT_SEND_CYCLES  = 2;
  localparam int TX_DEFAULT_BUSY_TIMEOUT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection. The search starts just above
// ptr and wraps, so the last requester served has the lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          grant_en,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] idx;

  // Walk ptr+1, ptr+2, ... (mod N); the first set request wins.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    idx        = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (grant_en && !gnt_valid && req[idx]) begin
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = idx;
        gnt_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Shares one serial transmitter between N_REQ requesters: round-robin grant,
// word capture, fixed-length send pulse, busy handshake tracking, and a
// sticky timeout flag when the transmitter never reports busy.
module tx_scheduler
  import tx_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = TX_WIDTH,
  parameter int SEND_CYCLES  = TX_DEFAULT_SEND_CYCLES,
  parameter int BUSY_TIMEOUT = TX_DEFAULT_BUSY_TIMEOUT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   palavra_req,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic [$clog2(N_REQ)-1:0] active_id,
  output logic                     tx_send,
  output logic [WIDTH-1:0]         tx_palavra,
  input  logic                     tx_busy,
  output logic                     err_timeout,
  input  logic                     err_clear
);

  localparam int              IW        = $clog2(N_REQ);
  localparam logic [3:0]      SEND_LAST = 4'(SEND_CYCLES);
  localparam logic [7:0]      TMO_LIMIT = 8'(BUSY_TIMEOUT);
  localparam logic [IW-1:0]   PTR_RESET = IW'(N_REQ - 1);

  tx_sched_state_t state, state_d;
  logic [3:0]       send_cnt, send_cnt_d;
  logic [7:0]       tmo_cnt, tmo_cnt_d;
  logic             seen_busy, seen_busy_d;
  logic [IW-1:0]    ptr, ptr_d;
  logic [N_REQ-1:0] ack_d, done_d;
  logic [IW-1:0]    active_id_d;
  logic             tx_send_d;
  logic [WIDTH-1:0] tx_palavra_d;
  logic             err_d;

  logic [WIDTH-1:0] words [N_REQ];
  logic [N_REQ-1:0] gnt_onehot;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic             grant_en;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = palavra_req[g*WIDTH +: WIDTH];
  end

  // A grant is only possible from IDLE while the transmitter is free.
  assign grant_en = (state == IDLE) && !tx_busy;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req        (req),
    .ptr        (ptr),
    .grant_en   (grant_en),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  // Next-state and next-output logic; ack/done are single-cycle pulses.
  always_comb begin
    state_d      = state;
    send_cnt_d   = send_cnt;
    tmo_cnt_d    = tmo_cnt;
    seen_busy_d  = seen_busy;
    ptr_d        = ptr;
    ack_d        = '0;
    done_d       = '0;
    active_id_d  = active_id;
    tx_send_d    = tx_send;
    tx_palavra_d = tx_palavra;
    err_d        = err_clear ? 1'b0 : err_timeout;

    case (state)
      IDLE: begin
        if (gnt_valid) begin
          tx_palavra_d = words[gnt_idx];
          active_id_d  = gnt_idx;
          ack_d        = gnt_onehot;
          tx_send_d    = 1'b1;
          send_cnt_d   = 4'd1;
          tmo_cnt_d    = 8'd1;     // the send-rise cycle is the first counted cycle
          seen_busy_d  = 1'b0;
          state_d      = SEND;
        end
      end

      SEND: begin
        if (tx_busy) seen_busy_d = 1'b1;
        if (tmo_cnt != 8'hFF) tmo_cnt_d = tmo_cnt + 8'd1;
        if (send_cnt == SEND_LAST) begin
          tx_send_d = 1'b0;
          state_d   = WAIT_BUSY;
        end else begin
          send_cnt_d = send_cnt + 4'd1;
        end
      end

      WAIT_BUSY: begin
        if (seen_busy || tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt >= TMO_LIMIT) begin
          err_d   = 1'b1;          // a timeout outranks a simultaneous clear
          ptr_d   = active_id;
          state_d = IDLE;
        end else if (tmo_cnt != 8'hFF) begin
          tmo_cnt_d = tmo_cnt + 8'd1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d[active_id] = 1'b1;
          ptr_d             = active_id;
          state_d           = IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      send_cnt    <= '0;
      tmo_cnt     <= '0;
      seen_busy   <= 1'b0;
      ptr         <= PTR_RESET;
      ack         <= '0;
      done        <= '0;
      active_id   <= '0;
      tx_send     <= 1'b0;
      tx_palavra  <= '0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register takes the value
      // computed from pre-edge state, independent of statement order.
      state       <= state_d;
      send_cnt    <= send_cnt_d;
      tmo_cnt     <= tmo_cnt_d;
      seen_busy   <= seen_busy_d;
      ptr         <= ptr_d;
      ack         <= ack_d;
      done        <= done_d;
      active_id   <= active_id_d;
      tx_send     <= tx_send_d;
      tx_palavra  <= tx_palavra_d;
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: a timestamp-based transaction model
// predicts every output each cycle; directed scenarios add literal checks.
`timescale 1ns/1ps
module tb_tx_scheduler;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int SC    = 2;
  localparam int BT    = 8;
  localparam int IW    = 2;
  localparam int NEVER = 32'h3fff_ffff;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req;
  logic [N*W-1:0] palavra_req;
  logic [N-1:0]   ack, done;
  logic [IW-1:0]  active_id;
  logic           tx_send;
  logic [W-1:0]   tx_palavra;
  logic           tx_busy;
  logic           err_timeout;
  logic           err_clear;

  tx_scheduler #(
    .N_REQ(N), .WIDTH(W), .SEND_CYCLES(SC), .BUSY_TIMEOUT(BT)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .palavra_req(palavra_req),
    .ack(ack), .done(done), .active_id(active_id), .tx_send(tx_send),
    .tx_palavra(tx_palavra), .tx_busy(tx_busy), .err_timeout(err_timeout),
    .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] ack;
    logic [N-1:0] done;
    int           id;
    logic         send;
    logic [W-1:0] pal;
    logic         err;
  } outs_t;

  // Model: who is being served and when its send rose.
  int    ptr, win, t_rise;
  bit    serving, seen, waitdone;
  outs_t exp_cur, exp_next;

  // Bench state: requester word queues and the transmitter's busy window.
  logic [W-1:0] q [N][$];
  int  cyc;
  int  b_start, b_end;
  bit  force_busy, clr_pulse, clr_hold, clr_rand, rand_tx, prev_send, chk_en;
  int  fix_d, fix_l;
  bit  fix_never;
  int  glog [$];
  int  checks, failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, expv);
    end
  endtask

  function automatic outs_t reset_outs();
    outs_t o;
    o.ack = '0; o.done = '0; o.id = 0; o.send = 1'b0; o.pal = '0; o.err = 1'b0;
    return o;
  endfunction

  task automatic model_reset();
    ptr = N - 1; serving = 0; win = 0; t_rise = 0; seen = 0; waitdone = 0;
    exp_cur = reset_outs(); exp_next = reset_outs();
    b_start = NEVER; b_end = NEVER; prev_send = 0;
  endtask

  // Predict outputs for cycle cyc+1 from the inputs presented in cycle cyc.
  task automatic model_step();
    outs_t n;
    int age;
    bit fire;
    logic [N-1:0] r;
    if (!reset) begin
      model_reset();
      return;
    end
    n = exp_cur; n.ack = '0; n.done = '0; fire = 0;
    for (int i = 0; i < N; i++) r[i] = (q[i].size() != 0);
    if (!serving) begin
      if (r != '0 && !tx_busy) begin
        for (int k = 1; k <= N; k++)
          if (!serving && r[(ptr + k) % N]) begin
            win = (ptr + k) % N;
            serving = 1;
          end
        t_rise = cyc + 1; seen = 0; waitdone = 0;
        n.ack[win] = 1'b1; n.id = win; n.pal = q[win][0];
      end
    end else begin
      age = cyc - t_rise;
      if (age < SC) begin
        if (tx_busy) seen = 1;
      end else if (!waitdone) begin
        if (seen || tx_busy) waitdone = 1;
        else if (age + 1 >= BT) begin fire = 1; serving = 0; ptr = win; end
      end else if (!tx_busy) begin
        n.done[win] = 1'b1; serving = 0; ptr = win;
      end
    end
    n.send = serving && ((cyc + 1 - t_rise) < SC);
    n.err  = fire ? 1'b1 : (err_clear ? 1'b0 : exp_cur.err);
    exp_next = n;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i] = (q[i].size() != 0);
      palavra_req[i*W +: W] = req[i] ? q[i][0] : W'($urandom);
    end
    tx_busy   = force_busy || (cyc >= b_start && cyc < b_end);
    err_clear = clr_pulse || clr_hold || (clr_rand && ($urandom_range(0, 19) == 0));
  endtask

  // Transmitter reaction to a send rise in the current cycle.
  task automatic schedule_tx();
    int d, l;
    bit nv;
    if (rand_tx) begin
      nv = ($urandom_range(0, 7) == 0); d = $urandom_range(0, 9); l = $urandom_range(1, 5);
    end else begin
      nv = fix_never; d = fix_d; l = fix_l;
    end
    if (nv) begin b_start = NEVER; b_end = NEVER; end
    else begin b_start = cyc + d; b_end = b_start + l; end
  endtask

  task automatic tick();
    drive_inputs();
    model_step();
    @(posedge clock); #1;
    cyc++;
    exp_cur = exp_next;
    clr_pulse = 0;
    if (reset) begin
      for (int i = 0; i < N; i++)
        if (exp_cur.ack[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (exp_cur.send && !prev_send) schedule_tx();
      prev_send = exp_cur.send;
      for (int i = 0; i < N; i++) if (ack[i]) glog.push_back(i);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("ack",         32'(ack),         32'(exp_cur.ack));
      check("done",        32'(done),        32'(exp_cur.done));
      check("active_id",   32'(active_id),   32'(exp_cur.id));
      check("tx_send",     32'(tx_send),     32'(exp_cur.send));
      check("tx_palavra",  32'(tx_palavra),  32'(exp_cur.pal));
      check("err_timeout", 32'(err_timeout), 32'(exp_cur.err));
    end
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; chk_en = 0;
    force_busy = 0; clr_pulse = 0; clr_hold = 0; clr_rand = 0; rand_tx = 0;
    fix_d = 1; fix_l = 2; fix_never = 0;
    model_reset();
    drive_inputs();

    // Reset state
    #2 reset = 1'b0; chk_en = 1;
    #1;
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_active_id", 32'(active_id), 32'd0);
    check("rst_tx_palavra", 32'(tx_palavra), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Single request: busy rises 3 cycles after send rise, lasts 4 cycles
    fix_d = 3; fix_l = 4;
    q[0].push_back(16'hABCD);
    tick();
    check("single_ack", 32'(ack), 32'h1);
    check("single_send1", 32'(tx_send), 32'd1);
    check("single_word", 32'(tx_palavra), 32'hABCD);
    check("single_id", 32'(active_id), 32'd0);
    tick();
    check("single_ack_pulse", 32'(ack), 32'h0);
    check("single_send2", 32'(tx_send), 32'd1);
    tick();
    check("single_send_drop", 32'(tx_send), 32'd0);
    repeat (5) tick();
    check("single_done_early", 32'(done), 32'h0);
    tick();
    check("single_done", 32'(done), 32'h1);
    tick();
    check("single_done_pulse", 32'(done), 32'h0);
    repeat (3) tick();

    // Contention from a fresh reset: grants 0,1,2,3
    reset = 1'b0; model_reset(); tick(); tick(); reset = 1'b1;
    fix_d = 1; fix_l = 2;
    glog.delete();
    q[0].push_back(16'h1111); q[1].push_back(16'h2222);
    q[2].push_back(16'h3333); q[3].push_back(16'h4444);
    for (int k = 0; k < 60 && glog.size() < 4; k++) tick();
    check("cont_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < glog.size(); i++) check("cont_order", 32'(glog[i]), 32'(i));
    repeat (8) tick();

    // Fairness: requesters 1 and 2 always requesting alternate
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      q[1].push_back(W'($urandom)); q[2].push_back(W'($urandom));
    end
    for (int k = 0; k < 100 && glog.size() < 8; k++) tick();
    check("fair_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < glog.size(); i++) check("fair_order", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    repeat (8) tick();

    // Timeout: busy never rises
    fix_never = 1;
    q[2].push_back(16'h2BAD);
    tick();
    check("tmo_ack", 32'(ack), 32'h4);
    repeat (7) tick();
    check("tmo_err_early", 32'(err_timeout), 32'd0);
    tick();
    check("tmo_err_set", 32'(err_timeout), 32'd1);
    check("tmo_no_done", 32'(done), 32'h0);
    fix_never = 0;
    q[1].push_back(16'h1234);
    tick();
    check("tmo_next_grant", 32'(ack), 32'h2);
    check("tmo_err_sticky", 32'(err_timeout), 32'd1);
    repeat (8) tick();
    clr_pulse = 1;
    tick();
    check("tmo_err_clear", 32'(err_timeout), 32'd0);

    // Timeout while err_clear is held: the set wins for one cycle
    fix_never = 1; clr_hold = 1;
    q[2].push_back(16'h0BAD);
    tick();
    repeat (7) tick();
    check("setwin_early", 32'(err_timeout), 32'd0);
    tick();
    check("setwin_set", 32'(err_timeout), 32'd1);
    tick();
    check("setwin_cleared", 32'(err_timeout), 32'd0);
    clr_hold = 0; fix_never = 0;
    repeat (2) tick();

    // Reset during WAIT_DONE
    fix_d = 1; fix_l = 20;
    q[3].push_back(16'h5555);
    tick();
    q[1].push_back(16'h1001); q[3].push_back(16'h3003);
    repeat (3) tick();
    check("mid_word", 32'(tx_palavra), 32'h5555);
    check("mid_id", 32'(active_id), 32'd3);
    #2 reset = 1'b0; model_reset();
    #1;
    check("mid_rst_send", 32'(tx_send), 32'd0);
    check("mid_rst_word", 32'(tx_palavra), 32'd0);
    check("mid_rst_id", 32'(active_id), 32'd0);
    check("mid_rst_done", 32'(done), 32'h0);
    tick(); tick();
    reset = 1'b1;
    fix_l = 2;
    glog.delete();
    for (int k = 0; k < 40 && glog.size() < 2; k++) tick();
    check("mid_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("mid_first", 32'(glog[0]), 32'd1);
      check("mid_second", 32'(glog[1]), 32'd3);
    end
    repeat (30) tick();

    // Busy in IDLE blocks the grant until it falls
    force_busy = 1;
    q[0].push_back(16'h0F0F);
    repeat (4) begin
      tick();
      check("bidle_no_ack", 32'(ack), 32'h0);
      check("bidle_no_send", 32'(tx_send), 32'd0);
    end
    force_busy = 0;
    tick();
    check("bidle_ack", 32'(ack), 32'h1);
    check("bidle_send", 32'(tx_send), 32'd1);
    check("bidle_word", 32'(tx_palavra), 32'h0F0F);
    repeat (10) tick();

    // Randomized traffic, transmitter timing and err_clear
    rand_tx = 1; clr_rand = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (q[r].size() < 3) q[r].push_back(W'($urandom));
      end
      tick();
    end
    repeat (60) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
